buffer_wr_arbiter: RTL and testbench

Write-port controller for the dual-port frame buffer (`buffer_ram_dp`). It shares the single write port between two pixel-write requesters: requester 0 is the game FSM and requester 1 is auxiliary logic such as button or overlay writers. It uses round-robin arbitration with a valid/ready handshake. It also contains a built-in clear sequencer that fills every buffer location with a fixed colour.

---
 rtl/buffer_wr_arbiter.sv | 86 ++++++++
 tb/tb_buffer_wr_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_wr_arbiter.sv
// buffer_wr_arbiter: round-robin write-port arbiter for the frame buffer with a built-in clear sequencer.
// Optional macro VBLANK_GATE_EN restricts all writes to cycles where vblank is high.
module buffer_wr_arbiter #(
    parameter int AW = 6,
    parameter int DW = 6,
    parameter logic [DW-1:0] CLEAR_COLOR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_start,
    output logic          clear_busy,
    input  logic          r0_valid,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_data,
    output logic          r0_ready,
    input  logic          r1_valid,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_data,
    output logic          r1_ready,
    input  logic          vblank,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_we,
    output logic          last_grant
);
    localparam logic ARB   = 1'b0;
    localparam logic CLEAR = 1'b1;

    logic          state_q, state_d, ptr_q, ptr_d, mem_we_q, mem_we_d, last_grant_q, last_grant_d;
    logic [AW-1:0] cnt_q, cnt_d, mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic          gate, in_arb, open_arb, g0, g1, step;

`ifdef VBLANK_GATE_EN
    assign gate = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign gate = 1'b1;
`endif

    // A pending clear_start blocks grants so the clear always wins the cycle.
    assign in_arb   = state_q == ARB;
    assign open_arb = in_arb & gate & ~clear_start;
    assign g0       = open_arb & r0_valid & (~r1_valid | ~ptr_q);
    assign g1       = open_arb & r1_valid & (~r0_valid | ptr_q);
    assign step     = ~in_arb & gate;

    assign r0_ready   = rst & g0;
    assign r1_ready   = rst & g1;
    assign clear_busy = state_q == CLEAR;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_we     = mem_we_q;
    assign last_grant = last_grant_q;

    always_comb begin
        state_d      = in_arb ? (clear_start ? CLEAR : ARB) : ((step && &cnt_q) ? ARB : CLEAR);
        cnt_d        = in_arb ? '0 : cnt_q + AW'(step);
        mem_we_d     = g0 | g1 | step;
        mem_addr_d   = step ? cnt_q : g1 ? r1_addr : g0 ? r0_addr : mem_addr_q;
        mem_data_d   = step ? CLEAR_COLOR : g1 ? r1_data : g0 ? r0_data : mem_data_q;
        ptr_d        = g0 ? 1'b1 : g1 ? 1'b0 : ptr_q;
        last_grant_d = g0 ? 1'b0 : g1 ? 1'b1 : last_grant_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB;
            ptr_q        <= 1'b0;
            cnt_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            last_grant_q <= last_grant_d;
        end
    end
endmodule

// File: tb/tb_buffer_wr_arbiter.sv
// tb_buffer_wr_arbiter: checks buffer_wr_arbiter against a transaction-level model of arbitration and clearing.
module tb_buffer_wr_arbiter;
    localparam int AW = 6;
    localparam int DW = 6;
    localparam int DEPTH = 64;
    localparam logic [DW-1:0] CC = 6'b101101;

    logic          clk = 0, rst = 0, clear_start = 0, vblank = 1, r0_valid = 0, r1_valid = 0;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0;
    logic [DW-1:0] r0_data = '0, r1_data = '0;
    logic          clear_busy, r0_ready, r1_ready, mem_we, last_grant;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    int            n_checks = 0, n_fail = 0;

    bit            m_clear, m_ptr, m_we, m_lg;
    int            m_left;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [AW+DW+2:0] obs, exp_o;
    logic [1:0]    exp_r;

    always #5 clk = ~clk;

    buffer_wr_arbiter #(.AW(AW), .DW(DW), .CLEAR_COLOR(CC)) dut (
        .clk(clk), .rst(rst), .clear_start(clear_start), .clear_busy(clear_busy),
        .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ready(r0_ready),
        .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ready(r1_ready),
        .vblank(vblank), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .last_grant(last_grant)
    );

    function automatic bit gate_open();
`ifdef VBLANK_GATE_EN
        return vblank;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int winner();
        if (!rst || m_clear || clear_start || !gate_open()) return -1;
        if (r0_valid && r1_valid) return int'(m_ptr);
        if (r0_valid) return 0;
        if (r1_valid) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_clear = 0; m_ptr = 0; m_we = 0; m_lg = 0; m_left = 0; m_addr = '0; m_data = '0;
    endtask

    task automatic tick();
        int w;
        w = winner();
        if (m_clear) begin
            m_we = gate_open();
            if (m_we) begin
                m_addr = AW'(DEPTH - m_left);
                m_data = CC;
                m_left--;
                m_clear = m_left != 0;
            end
        end else if (clear_start) begin
            m_clear = 1; m_left = DEPTH; m_we = 0;
        end else if (w == 0) begin
            m_we = 1; m_addr = r0_addr; m_data = r0_data; m_ptr = 1; m_lg = 0;
        end else if (w == 1) begin
            m_we = 1; m_addr = r1_addr; m_data = r1_data; m_ptr = 0; m_lg = 1;
        end else m_we = 0;
        @(posedge clk);
        #1;
        obs   = {mem_we, mem_addr, mem_data, clear_busy, last_grant};
        exp_o = {m_we, m_addr, m_data, m_clear, m_lg};
    endtask

    task automatic do_reset();
        rst = 0; clear_start = 0; r0_valid = 0; r1_valid = 0; vblank = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0; r0_valid = 1; r1_valid = 1;
        #1;
        n_checks++;
        if ({r0_ready, r1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {r0_ready, r1_ready}); end
        n_checks++;
        if ({mem_we, mem_addr, mem_data, clear_busy, last_grant} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", {mem_we, mem_addr, mem_data, clear_busy, last_grant});
        end
        r0_valid = 0; r1_valid = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic test_single_write();
        r0_valid = 1; r0_addr = 5; r0_data = 6'b110000;
        #1;
        n_checks++;
        if ({r0_ready, r1_ready} !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b want 10", {r0_ready, r1_ready}); end
        tick();
        r0_valid = 0;
        n_checks++;
        if (obs !== {1'b1, 6'd5, 6'b110000, 1'b0, 1'b0}) begin n_fail++; $display("FAIL single_write: got %h want %h", obs, {1'b1, 6'd5, 6'b110000, 1'b0, 1'b0}); end
        #1;
        tick();
        n_checks++;
        if (obs !== exp_o || mem_we !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %h want %h", obs, exp_o); end
    endtask

    task automatic test_contention();
        int pulses;
        pulses = 0;
        do_reset();
        r0_addr = 10; r0_data = 6'h11; r1_addr = 20; r1_data = 6'h22;
        for (int i = 0; i < 6; i++) begin
            r0_valid = 1; r1_valid = 1;
            #1;
            n_checks++;
            if ({r0_ready, r1_ready} !== {i % 2 == 0, i % 2 == 1}) begin
                n_fail++; $display("FAIL contention_ready[%0d]: got %b want %b", i, {r0_ready, r1_ready}, {i % 2 == 0, i % 2 == 1});
            end
            tick();
            pulses += int'(mem_we);
            n_checks++;
            if (last_grant !== 1'(i % 2) || mem_addr !== (i % 2 == 0 ? 6'd10 : 6'd20) || obs !== exp_o) begin
                n_fail++; $display("FAIL contention_grant[%0d]: got %h want %h", i, obs, exp_o);
            end
        end
        r0_valid = 0; r1_valid = 0;
        n_checks++;
        if (pulses != 6) begin n_fail++; $display("FAIL contention_pulses: got %0d want 6", pulses); end
    endtask

    task automatic test_clear();
        clear_start = 1; r0_valid = 1; r0_addr = 3; r0_data = 6'h3c; vblank = 1;
        #1;
        n_checks++;
        if ({r0_ready, r1_ready} !== 2'b00) begin n_fail++; $display("FAIL clear_start_ready: got %b want 00", {r0_ready, r1_ready}); end
        tick();
        clear_start = 0;
        n_checks++;
        if (obs !== exp_o || clear_busy !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL clear_enter: got %h want %h", obs, exp_o); end
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            n_checks++;
            if ({r0_ready, r1_ready} !== 2'b00) begin n_fail++; $display("FAIL clear_ready[%0d]: got %b want 00", i, {r0_ready, r1_ready}); end
            tick();
            n_checks++;
            if ({mem_we, mem_addr, mem_data, clear_busy} !== {1'b1, 6'(i), CC, i != DEPTH - 1} || obs !== exp_o) begin
                n_fail++; $display("FAIL clear_write[%0d]: got %h want %h", i, obs, exp_o);
            end
        end
        #1;
        n_checks++;
        if (r0_ready !== 1'b1) begin n_fail++; $display("FAIL clear_resume: got %b want 1", r0_ready); end
        tick();
        r0_valid = 0;
        n_checks++;
        if (obs !== exp_o) begin n_fail++; $display("FAIL clear_resume_write: got %h want %h", obs, exp_o); end
    endtask

    task automatic test_simultaneous();
        clear_start = 1; r1_valid = 1; r1_addr = 33; r1_data = 6'h07;
        #1;
        n_checks++;
        if (r1_ready !== 1'b0) begin n_fail++; $display("FAIL simul_ready: got %b want 0", r1_ready); end
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            clear_start = (i == 30);
            #1;
            n_checks++;
            if ({r0_ready, r1_ready} !== 2'b00) begin n_fail++; $display("FAIL simul_clear_ready[%0d]: got %b want 00", i, {r0_ready, r1_ready}); end
            tick();
            n_checks++;
            if (mem_addr !== 6'(i) || obs !== exp_o) begin n_fail++; $display("FAIL simul_clear[%0d]: got %h want %h", i, obs, exp_o); end
        end
        clear_start = 0;
        #1;
        n_checks++;
        if (r1_ready !== 1'b1) begin n_fail++; $display("FAIL simul_r1_after: got %b want 1", r1_ready); end
        tick();
        r1_valid = 0;
        n_checks++;
        if ({mem_we, mem_addr, mem_data, last_grant} !== {1'b1, 6'd33, 6'h07, 1'b1} || obs !== exp_o) begin
            n_fail++; $display("FAIL simul_r1_write: got %h want %h", obs, exp_o);
        end
    endtask

    task automatic test_reset_mid_clear();
        clear_start = 1;
        #1;
        tick();
        clear_start = 0; r0_valid = 1; r1_valid = 1;
        repeat (20) tick();
        n_checks++;
        if (obs !== exp_o || mem_addr !== 6'd19) begin n_fail++; $display("FAIL midclear_progress: got %h want %h", obs, exp_o); end
        #2;
        rst = 0;
        #1;
        n_checks++;
        if ({mem_we, clear_busy, r0_ready, r1_ready} !== 4'b0000) begin
            n_fail++; $display("FAIL midclear_async: got %b want 0000", {mem_we, clear_busy, r0_ready, r1_ready});
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
        #1;
        n_checks++;
        if ({r0_ready, r1_ready} !== 2'b10) begin n_fail++; $display("FAIL midclear_ptr: got %b want 10", {r0_ready, r1_ready}); end
        tick();
        r0_valid = 0; r1_valid = 0;
        n_checks++;
        if (obs !== exp_o) begin n_fail++; $display("FAIL midclear_after: got %h want %h", obs, exp_o); end
    endtask

    task automatic test_random(input int cycles, input int clr_pct);
        bit a0, a1;
        a0 = 0; a1 = 0;
        for (int i = 0; i < cycles; i++) begin
            if (r0_valid && !a0) begin
                if ($urandom_range(9) == 0) r0_valid = 0;
            end else begin
                r0_valid = 1'($urandom_range(1)); r0_addr = AW'($urandom); r0_data = DW'($urandom);
            end
            if (r1_valid && !a1) begin
                if ($urandom_range(9) == 0) r1_valid = 0;
            end else begin
                r1_valid = 1'($urandom_range(1)); r1_addr = AW'($urandom); r1_data = DW'($urandom);
            end
            clear_start = $urandom_range(99) < clr_pct;
            vblank = $urandom_range(3) != 0;
            #1;
            exp_r = {winner() == 0, winner() == 1};
            a0 = exp_r[1]; a1 = exp_r[0];
            n_checks++;
            if ({r0_ready, r1_ready} !== exp_r) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", i, {r0_ready, r1_ready}, exp_r); end
            tick();
            n_checks++;
            if (obs !== exp_o) begin n_fail++; $display("FAIL rand_out[%0d]: got %h want %h", i, obs, exp_o); end
        end
        clear_start = 0; r0_valid = 0; r1_valid = 0; vblank = 1;
    endtask

`ifdef VBLANK_GATE_EN
    task automatic test_vblank();
        int writes, open, cyc;
        do_reset();
        vblank = 0; r0_valid = 1; r0_addr = 9; r0_data = 6'h2a;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (r0_ready !== 1'b0) begin n_fail++; $display("FAIL vb_closed_ready[%0d]: got %b want 0", i, r0_ready); end
            tick();
            n_checks++;
            if (mem_we !== 1'b0) begin n_fail++; $display("FAIL vb_closed_we[%0d]: got %b want 0", i, mem_we); end
        end
        vblank = 1;
        #1;
        n_checks++;
        if (r0_ready !== 1'b1) begin n_fail++; $display("FAIL vb_open_ready: got %b want 1", r0_ready); end
        tick();
        r0_valid = 0;
        n_checks++;
        if (obs !== exp_o || mem_we !== 1'b1) begin n_fail++; $display("FAIL vb_open_write: got %h want %h", obs, exp_o); end
        vblank = 0; clear_start = 1;
        #1;
        tick();
        clear_start = 0;
        writes = 0; open = 0; cyc = 0;
        while (m_clear && cyc < 300) begin
            vblank = (cyc / 8) % 2 == 1;
            open += int'(vblank);
            #1;
            tick();
            writes += int'(mem_we);
            cyc++;
            n_checks++;
            if (obs !== exp_o) begin n_fail++; $display("FAIL vb_clear[%0d]: got %h want %h", cyc, obs, exp_o); end
        end
        n_checks++;
        if (writes != DEPTH || open != DEPTH || clear_busy !== 1'b0) begin
            n_fail++; $display("FAIL vb_clear_len: got writes %0d open %0d want %0d", writes, open, DEPTH);
        end
        vblank = 1;
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_clear();
        test_simultaneous();
        test_reset_mid_clear();
        test_random(500, 2);
`ifdef VBLANK_GATE_EN
        test_vblank();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
